// File: rtl/irq_axil_notifier_pkg.sv
// Shared types and constants for the IRQ-to-AXI-Lite notifier.
// Holds the FSM state encoding, the OKAY response code and a width helper.
package irq_axil_notifier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] axil_resp_okay = 2'b00;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner when the grant is consumed (yumi).
module bsg_arb_round_robin
  import irq_axil_notifier_pkg::*;
#(
  parameter  int unsigned width_p = 2,
  localparam int unsigned idx_w   = clog2_min1(width_p)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [width_p-1:0] reqs_i,
  input  logic               yumi_i,
  output logic               grant_v_o,
  output logic [idx_w-1:0]   grant_idx_o
);

  localparam int unsigned pad_w = 1 << idx_w;

  logic [idx_w-1:0] ptr_q, ptr_d;
  logic [pad_w-1:0] reqs_pad;
  logic [idx_w:0]   cand_sum;
  logic [idx_w-1:0] cand;
  logic [idx_w:0]   next_sum;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    reqs_pad               = '0;
    reqs_pad[width_p-1:0]  = reqs_i;
    grant_v_o              = 1'b0;
    grant_idx_o            = '0;
    cand_sum               = '0;
    cand                   = '0;
    // Walk downward so the candidate closest to the pointer wins last.
    for (int i = int'(width_p) - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr_q} + (idx_w+1)'(i);
      if (cand_sum >= (idx_w+1)'(width_p)) begin
        cand_sum = cand_sum - (idx_w+1)'(width_p);
      end
      cand = cand_sum[idx_w-1:0];
      if (reqs_pad[cand]) begin
        grant_v_o   = 1'b1;
        grant_idx_o = cand;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    next_sum = {1'b0, grant_idx_o} + (idx_w+1)'(1);
    if (next_sum >= (idx_w+1)'(width_p)) begin
      next_sum = '0;
    end
    if (yumi_i && grant_v_o) begin
      ptr_d = next_sum[idx_w-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/irq_axil_notifier.sv
// Forwards per-target interrupt level changes as posted AXI4-Lite writes,
// one outstanding at a time, round-robin, with bounded retry on error.
module irq_axil_notifier
  import irq_axil_notifier_pkg::*;
#(
  parameter int unsigned num_targets_p     = 2,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32,
  parameter logic [63:0] base_addr_p       = 64'h30_a000,
  parameter logic [63:0] target_stride_p   = 64'h8,
  parameter int unsigned max_retries_p     = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [num_targets_p-1:0]         irq_i,

  output logic [axil_addr_width_p-1:0]     m_axil_awaddr_o,
  output logic [2:0]                       m_axil_awprot_o,
  output logic                             m_axil_awvalid_o,
  input  logic                             m_axil_awready_i,

  output logic [axil_data_width_p-1:0]     m_axil_wdata_o,
  output logic [(axil_data_width_p>>3)-1:0] m_axil_wstrb_o,
  output logic                             m_axil_wvalid_o,
  input  logic                             m_axil_wready_i,

  input  logic [1:0]                       m_axil_bresp_i,
  input  logic                             m_axil_bvalid_i,
  output logic                             m_axil_bready_o,

  output logic [axil_addr_width_p-1:0]     m_axil_araddr_o,
  output logic [2:0]                       m_axil_arprot_o,
  output logic                             m_axil_arvalid_o,
  output logic                             m_axil_rready_o,
  input  logic [axil_data_width_p-1:0]     m_axil_rdata_i,
  input  logic [1:0]                       m_axil_rresp_i,
  input  logic                             m_axil_rvalid_i,
  input  logic                             m_axil_arready_i,

  output logic                             busy_o,
  output logic [num_targets_p-1:0]         err_o
);

  localparam int unsigned idx_w   = clog2_min1(num_targets_p);
  localparam int unsigned retry_w = clog2_min1(max_retries_p + 1);

  state_e                          state_q, state_d;
  logic [num_targets_p-1:0]        irq_q, irq_d;
  logic [num_targets_p-1:0]        sent_q, sent_d;
  logic [num_targets_p-1:0]        err_q, err_d;
  logic [idx_w-1:0]                tgt_q, tgt_d;
  logic                            data_q, data_d;
  logic [retry_w-1:0]              retry_q, retry_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic [axil_addr_width_p-1:0]    awaddr_q, awaddr_d;
  logic [axil_data_width_p-1:0]    wdata_q, wdata_d;

  logic [num_targets_p-1:0]        dirty;
  logic                            grant_v;
  logic [idx_w-1:0]                grant_idx;
  logic                            yumi;
  logic                            aw_done;
  logic                            w_done;

  assign irq_d = irq_i;
  assign dirty = irq_q ^ sent_q;

  bsg_arb_round_robin #(
    .width_p(num_targets_p)
  ) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .reqs_i     (dirty),
    .yumi_i     (yumi),
    .grant_v_o  (grant_v),
    .grant_idx_o(grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    sent_d    = sent_q;
    err_d     = err_q;
    tgt_d     = tgt_q;
    data_d    = data_q;
    retry_d   = retry_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    yumi      = 1'b0;
    aw_done   = 1'b0;
    w_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_v) begin
          yumi       = 1'b1;
          state_d    = SEND;
          tgt_d      = grant_idx;
          data_d     = irq_q[grant_idx];
          retry_d    = '0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = axil_addr_width_p'(base_addr_p + 64'(grant_idx) * target_stride_p);
          wdata_d    = '0;
          wdata_d[0] = irq_q[grant_idx];
        end
      end

      SEND: begin
        // A channel counts as done once its valid has already dropped.
        aw_done = !awvalid_q || m_axil_awready_i;
        w_done  = !wvalid_q  || m_axil_wready_i;
        if (awvalid_q && m_axil_awready_i) awvalid_d = 1'b0;
        if (wvalid_q  && m_axil_wready_i)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end

      RESP: begin
        if (m_axil_bvalid_i) begin
          bready_d = 1'b0;
          if (m_axil_bresp_i == axil_resp_okay) begin
            sent_d[tgt_q] = data_q;
            state_d       = IDLE;
          end else if (retry_q < retry_w'(max_retries_p)) begin
            // Re-issue the identical write; address and data are still held.
            retry_d   = retry_q + retry_w'(1);
            state_d   = SEND;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            sent_d[tgt_q] = data_q;
            err_d[tgt_q]  = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      sent_q    <= '0;
      err_q     <= '0;
      tgt_q     <= '0;
      data_q    <= 1'b0;
      retry_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
      tgt_q     <= tgt_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign m_axil_awaddr_o  = awaddr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = '1;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;

  // The read channel is never used by this master.
  assign m_axil_araddr_o  = '0;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = 1'b0;
  assign m_axil_rready_o  = 1'b0;

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  logic unused_read_inputs;
  assign unused_read_inputs = ^{m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i, m_axil_arready_i};

endmodule

// File: tb/tb_irq_axil_notifier.sv
// Self-checking bench: transaction-level reference model plus directed
// scenarios with literal expectations and a randomized soak phase.
module tb_irq_axil_notifier;

  localparam int NT    = 4;
  localparam int MAXR  = 3;
  localparam logic [31:0] BASE   = 32'h0030_a000;
  localparam logic [31:0] STRIDE = 32'h8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NT-1:0] irq = '0;
  logic [31:0]   awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [31:0]   araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          rready;
  logic [31:0]   rdata = 32'hdead_beef;
  logic [1:0]    rresp = 2'b11;
  logic          rvalid = 1'b0;
  logic          arready = 1'b0;
  logic          busy;
  logic [NT-1:0] err;

  irq_axil_notifier #(
    .num_targets_p    (NT),
    .axil_data_width_p(32),
    .axil_addr_width_p(32),
    .base_addr_p      (64'h30_a000),
    .target_stride_p  (64'h8),
    .max_retries_p    (MAXR)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .irq_i            (irq),
    .m_axil_awaddr_o  (awaddr),
    .m_axil_awprot_o  (awprot),
    .m_axil_awvalid_o (awvalid),
    .m_axil_awready_i (awready),
    .m_axil_wdata_o   (wdata),
    .m_axil_wstrb_o   (wstrb),
    .m_axil_wvalid_o  (wvalid),
    .m_axil_wready_i  (wready),
    .m_axil_bresp_i   (bresp),
    .m_axil_bvalid_i  (bvalid),
    .m_axil_bready_o  (bready),
    .m_axil_araddr_o  (araddr),
    .m_axil_arprot_o  (arprot),
    .m_axil_arvalid_o (arvalid),
    .m_axil_rready_o  (rready),
    .m_axil_rdata_i   (rdata),
    .m_axil_rresp_i   (rresp),
    .m_axil_rvalid_i  (rvalid),
    .m_axil_arready_i (arready),
    .busy_o           (busy),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave behaviour knobs
  bit         rand_ready  = 1'b0;
  bit         rand_bdelay = 1'b0;
  int         bdelay      = 1;
  int         aw_stall    = 0;
  int         err_pct     = 0;
  logic [1:0] resp_queue[$];

  // Values seen in the cycle before the next rising edge
  logic          s_awv, s_awr, s_wv, s_wr, s_bv, s_br;
  logic [1:0]    s_bresp;
  logic [NT-1:0] s_irq;

  // Handshake logs
  int          aw_cyc[$];
  logic [31:0] aw_addr[$];
  int          w_cyc[$];
  logic [31:0] w_data[$];
  int          b_cyc[$];

  // Reference model: delivered levels, sticky errors, pointer, one write in flight
  logic [NT-1:0] m_irq, m_sent, m_err;
  int            m_ptr, m_tgt, m_tries;
  bit            m_act, m_data, m_aw_open, m_w_open, m_resp;

  task automatic model_reset();
    m_irq = '0; m_sent = '0; m_err = '0;
    m_ptr = 0; m_tgt = 0; m_tries = 0;
    m_act = 0; m_data = 0; m_aw_open = 0; m_w_open = 0; m_resp = 0;
  endtask

  task automatic model_step();
    logic [NT-1:0] pending;
    bit found;
    int t;
    pending = m_irq ^ m_sent;
    if (m_act) begin
      if (!m_resp) begin
        if (m_aw_open && s_awr) m_aw_open = 0;
        if (m_w_open && s_wr)   m_w_open  = 0;
        if (!m_aw_open && !m_w_open) m_resp = 1;
      end else if (s_bv) begin
        if (s_bresp == 2'b00 || m_tries == MAXR) begin
          m_sent[m_tgt] = m_data;
          if (s_bresp != 2'b00) m_err[m_tgt] = 1'b1;
          m_act = 0;
        end else begin
          m_tries++;
          m_aw_open = 1; m_w_open = 1; m_resp = 0;
        end
      end
    end else begin
      found = 0;
      for (int k = 0; k < NT; k++) begin
        t = (m_ptr + k) % NT;
        if (!found && pending[t]) begin
          found = 1;
          m_tgt = t;
        end
      end
      if (found) begin
        m_act = 1; m_data = m_irq[m_tgt]; m_tries = 0;
        m_aw_open = 1; m_w_open = 1; m_resp = 0;
        m_ptr = (m_tgt + 1) % NT;
      end
    end
    m_irq = s_irq;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic compare_outputs();
    bit exp_awv, exp_wv, exp_br;
    exp_awv = m_act && !m_resp && m_aw_open;
    exp_wv  = m_act && !m_resp && m_w_open;
    exp_br  = m_act && m_resp;
    check("busy", busy, m_act);
    check("awvalid", awvalid, exp_awv);
    check("wvalid", wvalid, exp_wv);
    check("bready", bready, exp_br);
    check("err", err, m_err);
    if (exp_awv) begin
      check("awaddr", awaddr, BASE + 32'(m_tgt) * STRIDE);
      check("awprot", awprot, 3'b000);
    end
    if (exp_wv) begin
      check("wdata", wdata, {31'b0, m_data});
      check("wstrb", wstrb, 4'hf);
    end
    check("read_idle", {arvalid, rready, araddr, arprot}, '0);
  endtask

  // Compare and log on the falling edge, then snapshot for the next edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      compare_outputs();
      if (awvalid && awready) begin aw_cyc.push_back(cyc); aw_addr.push_back(awaddr); end
      if (wvalid && wready)   begin w_cyc.push_back(cyc);  w_data.push_back(wdata);   end
      if (bvalid && bready)   b_cyc.push_back(cyc);
    end
    s_awv = awvalid; s_awr = awready; s_wv = wvalid; s_wr = wready;
    s_bv = bvalid; s_br = bready; s_bresp = bresp; s_irq = irq;
  end

  // AXI-Lite write slave
  bit got_aw = 0, got_w = 0;
  int bcnt = -1;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; got_aw = 0; got_w = 0; bcnt = -1;
    end else begin
      if (s_bv && s_br) bvalid = 0;
      if (s_awv && s_awr) got_aw = 1;
      if (s_wv && s_wr)   got_w  = 1;
      if (got_aw && got_w && !bvalid && bcnt < 0) begin
        bcnt   = rand_bdelay ? int'($urandom_range(0, 4)) : bdelay;
        got_aw = 0;
        got_w  = 0;
      end
      if (bcnt == 0) begin
        bvalid = 1;
        if (resp_queue.size() > 0) bresp = resp_queue.pop_front();
        else if (int'($urandom_range(0, 99)) < err_pct) bresp = 2'b10;
        else bresp = 2'b00;
        bcnt = -1;
      end else if (bcnt > 0) begin
        bcnt--;
      end
      if (aw_stall > 0) begin
        awready = 0;
        aw_stall--;
      end else begin
        awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    aw_cyc.delete(); aw_addr.delete(); w_cyc.delete(); w_data.delete(); b_cyc.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_awaddr"}, awaddr, 0);
    check({tag, "_wdata"}, wdata, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    irq = '0;
    aw_stall = 0; rand_ready = 0; rand_bdelay = 0; bdelay = 1; err_pct = 0;
    resp_queue.delete();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1;
    clear_logs();
    step(1);
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < budget) begin
      step(1);
      n++;
      if (!busy && !m_act) idle++;
      else idle = 0;
    end
    check({name, "_quiet"}, (idle >= 4), 1);
  endtask

  task automatic wait_bready(input int budget);
    int n = 0;
    while (!bready && n < budget) begin step(1); n++; end
    check("wait_bready", bready, 1);
  endtask

  task automatic wait_awvalid(input int budget);
    int n = 0;
    while (!awvalid && n < budget) begin step(1); n++; end
    check("wait_awvalid", awvalid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Simultaneous rise of all targets: served 0,1,2,3, four cycles apart
    do_reset();
    irq = 4'b1111;
    wait_quiet(100, "all4");
    check("all4_count", aw_addr.size(), 4);
    if (aw_addr.size() == 4) begin
      check("all4_addr0", aw_addr[0], 32'h30_a000);
      check("all4_addr1", aw_addr[1], 32'h30_a008);
      check("all4_addr2", aw_addr[2], 32'h30_a010);
      check("all4_addr3", aw_addr[3], 32'h30_a018);
      for (int i = 1; i < 4; i++) check("all4_gap", aw_cyc[i] - aw_cyc[i-1], 4);
    end
    check("all4_bcount", b_cyc.size(), 4);
    check("all4_busy_end", busy, 0);

    // Single rise on target 1, then drop
    do_reset();
    irq = 4'b0010;
    step(1);
    check("lat_awvalid_e1", awvalid, 0);
    step(1);
    check("lat_awvalid_e2", awvalid, 1);
    check("lat_awaddr", awaddr, 32'h30_a008);
    check("lat_wdata", wdata, 32'h1);
    wait_quiet(50, "rise");
    irq = 4'b0000;
    wait_quiet(50, "fall");
    check("single_count", w_data.size(), 2);
    if (w_data.size() == 2) begin
      check("single_addr", aw_addr[1], 32'h30_a008);
      check("single_data0", w_data[0], 32'h1);
      check("single_data1", w_data[1], 32'h0);
    end

    // Back-pressure: address channel stalled, data accepted first
    do_reset();
    aw_stall = 6;
    irq = 4'b0001;
    step(4);
    check("bp_awvalid_held", awvalid, 1);
    check("bp_wvalid_done", wvalid, 0);
    check("bp_awaddr_held", awaddr, 32'h30_a000);
    wait_quiet(60, "bp");
    check("bp_aw_count", aw_addr.size(), 1);
    check("bp_w_count", w_data.size(), 1);
    if (aw_cyc.size() == 1 && w_cyc.size() == 1) check("bp_w_first", (w_cyc[0] < aw_cyc[0]), 1);

    // Error retry: two errors then OKAY, then four errors exhaust retries
    do_reset();
    resp_queue = '{2'b10, 2'b10, 2'b00};
    irq = 4'b0100;
    wait_quiet(80, "retry_ok");
    check("retry_ok_count", aw_addr.size(), 3);
    foreach (aw_addr[i]) check("retry_ok_addr", aw_addr[i], 32'h30_a010);
    check("retry_ok_err", err, 4'b0000);
    clear_logs();
    resp_queue = '{2'b10, 2'b10, 2'b10, 2'b10};
    irq = 4'b0000;
    wait_quiet(80, "retry_drop");
    step(20);
    check("retry_drop_count", aw_addr.size(), 4);
    foreach (w_data[i]) check("retry_drop_data", w_data[i], 32'h0);
    check("retry_drop_err", err, 4'b0100);

    // Toggle during flight, then a 1-cycle pulse while another target is served
    do_reset();
    irq = 4'b0001;
    wait_bready(20);
    irq = 4'b0000;
    wait_quiet(60, "toggle");
    check("toggle_count", w_data.size(), 2);
    if (w_data.size() == 2) begin
      check("toggle_data0", w_data[0], 32'h1);
      check("toggle_data1", w_data[1], 32'h0);
    end
    clear_logs();
    irq = 4'b0010;
    wait_awvalid(20);
    irq = 4'b0011;
    step(1);
    irq = 4'b0010;
    wait_quiet(60, "pulse");
    check("pulse_count", aw_addr.size(), 1);
    if (aw_addr.size() == 1) check("pulse_addr", aw_addr[0], 32'h30_a008);

    // Reset while a write is stalled in SEND
    do_reset();
    aw_stall = 20;
    irq = 4'b1000;
    wait_awvalid(20);
    step(2);
    do_reset();
    step(20);
    check("post_reset_writes", aw_addr.size(), 0);
    check("post_reset_busy", busy, 0);

    // Randomized soak against the model
    do_reset();
    rand_ready = 1; rand_bdelay = 1; err_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(0, 5) == 0) irq = irq ^ NT'($urandom_range(1, (1 << NT) - 1));
    end
    wait_quiet(1000, "soak");
    check("soak_activity", (aw_addr.size() > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
